// File: rtl/serdesphy_tx_framer.sv
// SerDes PHY transmit framer: nibble packer, byte FIFO, Manchester encoder.
// Optional PRBS7 source under SERDESPHY_TX_PRBS_EN.
module serdesphy_tx_framer #(
  parameter int PREAMBLE_WORDS = 32,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic        clk_24m,
  input  logic        rst_n_24m,
  input  logic        tx_en,
  input  logic        tx_fifo_en,
  input  logic        tx_preamble_req,
  input  logic        tx_prbs_gen_en,
  input  logic [3:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [15:0] ser_word,
  output logic        ser_valid,
  input  logic        ser_ready,
  output logic        tx_fifo_full,
  output logic        tx_fifo_empty,
  output logic        tx_overflow,
  output logic        tx_underflow,
  output logic        tx_active,
  output logic        tx_preamble_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {DISABLED, PREAMBLE, ACTIVE} state_t;

  state_t      state_q;
  logic [7:0]  pcnt_q;
  logic        pat_q;
  logic [3:0]  nib_q;
  logic        ph_q;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] fcnt_q;
  logic [15:0] word_q;
  logic        vld_q, ovf_q, unf_q, done_q, sent_q;

  logic        full, empty, take, push, drop, pop, load, hs;
  logic        prbs_sel;
  logic [7:0]  prbs_b;
  logic [15:0] pat_w;

  function automatic logic [15:0] manch(input logic [7:0] b);
    logic [15:0] w;
    for (int i = 0; i < 8; i++)
      w[2*i +: 2] = b[i] ? 2'b10 : 2'b01;
    return w;
  endfunction

  assign full  = fcnt_q == CW'(FIFO_DEPTH);
  assign empty = fcnt_q == '0;
  assign take  = tx_valid & tx_en & tx_fifo_en & (state_q != DISABLED);
  assign push  = take & ph_q & ~full;
  assign drop  = take & ph_q & full;
  assign load  = ~vld_q | ser_ready;
  assign hs    = vld_q & ser_ready;
  assign pop   = (state_q == ACTIVE) & load & ~empty & ~prbs_sel;
  assign pat_w = pat_q ? 16'h5555 : 16'hAAAA;

`ifdef SERDESPHY_TX_PRBS_EN
  logic [6:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    prbs_b = '0;
    for (int i = 7; i >= 0; i--) begin
      prbs_b[i] = lfsr_d[6] ^ lfsr_d[5];
      lfsr_d    = {lfsr_d[5:0], prbs_b[i]};
    end
  end

  assign prbs_sel = tx_prbs_gen_en & (state_q == ACTIVE);

  always_ff @(posedge clk_24m or negedge rst_n_24m) begin
    if (!rst_n_24m)
      lfsr_q <= 7'h7F;
    else if (state_q == DISABLED || (tx_en && tx_preamble_req))
      lfsr_q <= 7'h7F;
    else if (tx_en && prbs_sel && load)
      lfsr_q <= lfsr_d;
  end
`else
  logic prbs_unused;
  assign prbs_unused = tx_prbs_gen_en;
  assign prbs_sel    = 1'b0;
  assign prbs_b      = '0;
`endif

  always_ff @(posedge clk_24m or negedge rst_n_24m) begin
    if (!rst_n_24m) begin
      state_q <= DISABLED;
      pcnt_q  <= '0;
      pat_q   <= 1'b0;
      nib_q   <= '0;
      ph_q    <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
      fcnt_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem_q[i] <= '0;
      word_q  <= '0;
      vld_q   <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      done_q  <= 1'b0;
      sent_q  <= 1'b0;
    end else if (!tx_en) begin
      state_q <= DISABLED;
      vld_q   <= 1'b0;
      ph_q    <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
      fcnt_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wp_q] <= {nib_q, tx_data};
        wp_q        <= wp_q + AW'(1);
      end
      if (pop)
        rp_q <= rp_q + AW'(1);
      fcnt_q <= fcnt_q + CW'(push) - CW'(pop);
      if (take)
        ph_q <= ~ph_q;
      if (take && !ph_q)
        nib_q <= tx_data;
      if (drop)
        ovf_q <= 1'b1;
      unique case (state_q)
        DISABLED: begin
          state_q <= PREAMBLE;
          pcnt_q  <= '0;
          pat_q   <= 1'b0;
          done_q  <= 1'b0;
        end
        PREAMBLE: begin
          if (load) begin
            word_q <= pat_w;
            pat_q  <= ~pat_q;
            vld_q  <= 1'b1;
          end
          if (hs) begin
            pcnt_q <= pcnt_q + 8'd1;
            if (pcnt_q == 8'(PREAMBLE_WORDS - 1)) begin
              state_q <= ACTIVE;
              done_q  <= 1'b1;
              sent_q  <= 1'b0;
            end
          end
        end
        ACTIVE: begin
          if (load) begin
            vld_q <= 1'b1;
            if (prbs_sel) begin
              word_q <= manch(prbs_b);
            end else if (!empty) begin
              word_q <= manch(mem_q[rp_q]);
              sent_q <= 1'b1;
            end else begin
              word_q <= pat_w;
              pat_q  <= ~pat_q;
              if (sent_q)
                unf_q <= 1'b1;
            end
          end
        end
        default: state_q <= DISABLED;
      endcase
      // Restart wins over a same-cycle preamble completion
      if (tx_preamble_req && state_q != DISABLED) begin
        state_q <= PREAMBLE;
        pcnt_q  <= '0;
        done_q  <= 1'b0;
      end
    end
  end

  assign tx_ready         = tx_en & tx_fifo_en & ~full;
  assign ser_word         = word_q;
  assign ser_valid        = vld_q;
  assign tx_fifo_full     = full;
  assign tx_fifo_empty    = empty;
  assign tx_overflow      = ovf_q;
  assign tx_underflow     = unf_q;
  assign tx_active        = state_q == ACTIVE;
  assign tx_preamble_done = done_q;

endmodule

// File: tb/tb_serdesphy_tx_framer.sv
// Scoreboard bench for serdesphy_tx_framer.
// Data words queued at push time; a negedge monitor checks handshakes.
module tb_serdesphy_tx_framer;

  logic        clk, rst_n;
  logic        tx_en, tx_fifo_en, tx_preamble_req, tx_prbs_gen_en;
  logic [3:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [15:0] ser_word;
  logic        ser_valid, ser_ready;
  logic        tx_fifo_full, tx_fifo_empty, tx_overflow, tx_underflow;
  logic        tx_active, tx_preamble_done;

  serdesphy_tx_framer #(.PREAMBLE_WORDS(32), .FIFO_DEPTH(4)) dut (
    .clk_24m(clk), .rst_n_24m(rst_n),
    .tx_en(tx_en), .tx_fifo_en(tx_fifo_en),
    .tx_preamble_req(tx_preamble_req), .tx_prbs_gen_en(tx_prbs_gen_en),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ser_word(ser_word), .ser_valid(ser_valid), .ser_ready(ser_ready),
    .tx_fifo_full(tx_fifo_full), .tx_fifo_empty(tx_fifo_empty),
    .tx_overflow(tx_overflow), .tx_underflow(tx_underflow),
    .tx_active(tx_active), .tx_preamble_done(tx_preamble_done)
  );

  initial clk = 1'b0;
  always #21 clk = ~clk;

  int errs = 0;
  int checks = 0;
  logic [15:0] expq[$];
  logic [15:0] exp_pat = 16'hAAAA;
  int pre_cnt = 0;
  bit mon_en = 1'b0;
  bit rnd = 1'b0;

  function automatic logic [15:0] menc(input logic [7:0] b);
    logic [15:0] w = '0;
    for (int i = 7; i >= 0; i--)
      w = {w[13:0], (b[i] ? 2'b10 : 2'b01)};
    return w;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && ser_valid && ser_ready) begin
      if (ser_word == 16'hAAAA || ser_word == 16'h5555) begin
        chk("pattern", {16'h0, ser_word}, {16'h0, exp_pat});
        exp_pat = ~exp_pat;
        if (!tx_preamble_done && !tx_active)
          pre_cnt++;
      end else if (expq.size() == 0) begin
        chk("spurious_word", {16'h0, ser_word}, 32'hFFFF_FFFF);
      end else begin
        chk("data_word", {16'h0, ser_word}, {16'h0, expq.pop_front()});
      end
    end
    if (!tx_en)
      exp_pat = 16'hAAAA;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_nib(input logic [3:0] d);
    tx_valid   = 1'b1;
    tx_data    = d;
    tx_fifo_en = 1'b1;
    cyc(1);
    tx_valid   = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ok);
    send_nib(b[7:4]);
    send_nib(b[3:0]);
    if (ok)
      expq.push_back(menc(b));
  endtask

  task automatic wait_done(input string nm);
    for (int n = 0; n < 300 && !tx_preamble_done; n++)
      cyc(1);
    chk(nm, {31'h0, tx_preamble_done}, 32'd1);
  endtask

  task automatic drain(input string nm);
    ser_ready = 1'b1;
    for (int n = 0; n < 200 && expq.size() != 0; n++)
      cyc(1);
    chk(nm, expq.size(), 0);
  endtask

  task automatic rand_traffic(input int nbytes);
    logic [7:0] b;
    int n;
    for (int k = 0; k < nbytes; k++) begin
      repeat ($urandom_range(0, 3)) begin
        tx_fifo_en = 1'b0;
        tx_valid   = 1'($urandom_range(0, 1));
        tx_data    = 4'($urandom);
        cyc(1);
      end
      tx_valid   = 1'b0;
      tx_fifo_en = 1'b1;
      b = 8'($urandom_range(1, 254));
      send_nib(b[7:4]);
      for (n = 0; n < 200 && !tx_ready; n++)
        cyc(1);
      if (n == 200)
        chk("ready_timeout", {31'h0, tx_ready}, 32'd1);
      send_nib(b[3:0]);
      expq.push_back(menc(b));
    end
  endtask

  logic [15:0] held;

  initial begin
    rst_n = 1'b0; tx_en = 1'b0; tx_fifo_en = 1'b0;
    tx_preamble_req = 1'b0; tx_prbs_gen_en = 1'b0;
    tx_data = '0; tx_valid = 1'b0; ser_ready = 1'b0;
    #30;
    chk("rst_valid", {31'h0, ser_valid}, 0);
    chk("rst_word", {16'h0, ser_word}, 0);
    chk("rst_empty", {31'h0, tx_fifo_empty}, 1);
    chk("rst_full", {31'h0, tx_fifo_full}, 0);
    chk("rst_ovf", {31'h0, tx_overflow}, 0);
    chk("rst_unf", {31'h0, tx_underflow}, 0);
    chk("rst_active", {31'h0, tx_active}, 0);
    chk("rst_done", {31'h0, tx_preamble_done}, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    mon_en = 1'b1;
    pre_cnt = 0;
    tx_en = 1'b1; tx_fifo_en = 1'b1; ser_ready = 1'b1;
    wait_done("pre1_done");
    chk("pre1_count", pre_cnt, 32);
    chk("pre1_active", {31'h0, tx_active}, 1);
    cyc(3);
    chk("idle_no_unf", {31'h0, tx_underflow}, 0);

    send_byte(8'hA5, 1'b1);
    cyc(6);
    chk("a5_sent", expq.size(), 0);
    chk("a5_unf", {31'h0, tx_underflow}, 1);

    chk("pre_ovf", {31'h0, tx_overflow}, 0);
    ser_ready = 1'b0;
    cyc(2);
    held = ser_word;
    chk("hold_valid", {31'h0, ser_valid}, 1);
    for (int k = 0; k < 4; k++)
      send_byte(8'($urandom_range(1, 254)), 1'b1);
    chk("full4", {31'h0, tx_fifo_full}, 1);
    chk("ready_low", {31'h0, tx_ready}, 0);
    send_byte(8'h3C, 1'b0);
    chk("ovf_set", {31'h0, tx_overflow}, 1);
    chk("word_held", {16'h0, ser_word}, {16'h0, held});
    drain("ovf_drain");

    ser_ready = 1'b0;
    cyc(2);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    chk("q2_nonempty", {31'h0, tx_fifo_empty}, 0);
    tx_en = 1'b0;
    cyc(1);
    chk("dis_valid", {31'h0, ser_valid}, 0);
    chk("dis_empty", {31'h0, tx_fifo_empty}, 1);
    expq.delete();
    chk("dis_ovf_kept", {31'h0, tx_overflow}, 1);
    chk("dis_unf_kept", {31'h0, tx_underflow}, 1);
    cyc(2);
    pre_cnt = 0;
    tx_en = 1'b1; ser_ready = 1'b1;
    begin
      int n;
      for (n = 0; n < 5 && !ser_valid; n++)
        cyc(1);
    end
    chk("reen_first", {16'h0, ser_word}, 32'h0000_AAAA);
    chk("reen_done", {31'h0, tx_preamble_done}, 0);
    wait_done("pre2_done");
    chk("pre2_count", pre_cnt, 32);

    cyc(3);
    pre_cnt = 0;
    tx_preamble_req = 1'b1;
    cyc(1);
    tx_preamble_req = 1'b0;
    chk("req_done_clr", {31'h0, tx_preamble_done}, 0);
    chk("req_inactive", {31'h0, tx_active}, 0);
    wait_done("pre3_done");
    chk("pre3_count", pre_cnt, 32);

    rnd = 1'b1;
    fork
      begin
        rand_traffic(40);
        rnd = 1'b0;
      end
      begin
        while (rnd) begin
          @(posedge clk);
          #1;
          ser_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain("rand_drain");
    chk("rand_no_new_ovf", {31'h0, tx_overflow}, 1);

`ifdef SERDESPHY_TX_PRBS_EN
    ser_ready = 1'b0;
    mon_en = 1'b0;
    cyc(2);
    send_byte(8'h3C, 1'b0);
    cyc(1);
    tx_prbs_gen_en = 1'b1;
    ser_ready = 1'b1;
    cyc(1);
    ser_ready = 1'b0;
    chk("prbs_first", {16'h0, ser_word}, 32'h0000_5559);
    chk("prbs_no_pop", {31'h0, tx_fifo_empty}, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
